// File: rtl/gray_ctrl_if.sv
// Bundle between gray_ctrl, its two requesters and the 3-bit Gray step counter.
// master = requesters plus counter side, slave = the controller.
interface gray_ctrl_if #(
    parameter int LEN_W = 4
);
    logic [1:0]       Req;
    logic [LEN_W-1:0] LenA;
    logic [LEN_W-1:0] LenB;
    logic [1:0]       Gnt;
    logic [1:0]       Done;
    logic             Busy;
    logic [2:0]       Result;
    logic             Wrap;
    logic             Cnt_clr;
    logic             Cnt_en;
    logic [2:0]       Cnt_val;
    logic             Cnt_ovf;

    modport master (
        output Req, LenA, LenB, Cnt_val, Cnt_ovf,
        input  Gnt, Done, Busy, Result, Wrap, Cnt_clr, Cnt_en
    );

    modport slave (
        input  Req, LenA, LenB, Cnt_val, Cnt_ovf,
        output Gnt, Done, Busy, Result, Wrap, Cnt_clr, Cnt_en
    );
endinterface

// File: rtl/gray_ctrl.sv
// Two-requester run scheduler that owns the 3-bit Gray step counter.
// Define GRAY_CTRL_RR_EN for round-robin arbitration; the default is fixed priority (A over B).
module gray_ctrl #(
    parameter int LEN_W = 4
) (
    input logic        Clk,
    input logic        Reset,
    gray_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] rem;
    logic             own;
    logic [1:0]       gnt_q;
    logic [1:0]       done_q;
    logic             busy_q;
    logic             clr_q;
    logic             en_q;
    logic             win;
    logic [LEN_W-1:0] win_len;

`ifdef GRAY_CTRL_RR_EN
    logic ptr;

    // The pointer only matters on a tie; a lone request always wins.
    always_comb begin
        win = 1'b0;
        if (bus.Req == 2'b11) begin
            win = ptr;
        end else begin
            win = bus.Req[1];
        end
    end
`else
    always_comb begin
        win = ~bus.Req[0];
    end
`endif

    assign win_len = win ? bus.LenB : bus.LenA;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state  <= IDLE;
            rem    <= '0;
            own    <= 1'b0;
            gnt_q  <= 2'b00;
            done_q <= 2'b00;
            busy_q <= 1'b0;
            clr_q  <= 1'b0;
            en_q   <= 1'b0;
`ifdef GRAY_CTRL_RR_EN
            ptr    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Req != 2'b00) begin
                        state  <= CLEAR;
                        rem    <= win_len;
                        own    <= win;
                        gnt_q  <= win ? 2'b10 : 2'b01;
                        busy_q <= 1'b1;
                        clr_q  <= 1'b1;
`ifdef GRAY_CTRL_RR_EN
                        ptr    <= ~win;
`endif
                    end
                end
                CLEAR: begin
                    gnt_q <= 2'b00;
                    clr_q <= 1'b0;
                    if (rem == '0) begin
                        state  <= DONE;
                        done_q <= own ? 2'b10 : 2'b01;
                    end else begin
                        state <= RUN;
                        en_q  <= 1'b1;
                    end
                end
                RUN: begin
                    rem <= rem - 1'b1;
                    // The last enable cycle is the one that sees rem == 1.
                    if (rem == LEN_W'(1)) begin
                        state  <= DONE;
                        en_q   <= 1'b0;
                        done_q <= own ? 2'b10 : 2'b01;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 2'b00;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    gnt_q  <= 2'b00;
                    done_q <= 2'b00;
                    busy_q <= 1'b0;
                    clr_q  <= 1'b0;
                    en_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Gnt     = gnt_q;
    assign bus.Done    = done_q;
    assign bus.Busy    = busy_q;
    assign bus.Cnt_clr = clr_q;
    assign bus.Cnt_en  = en_q;
    // The counter has settled by DONE, so its value is passed straight through.
    assign bus.Result  = (state == DONE) ? bus.Cnt_val : 3'b000;
    assign bus.Wrap    = (state == DONE) ? bus.Cnt_ovf : 1'b0;

endmodule

// File: doc/gray_ctrl.md
# gray_ctrl

Two-requester scheduler for the 3-bit Gray-code step counter. Requesters ask for a run of N counter steps; `gray_ctrl` arbitrates, clears the counter, drives its enable for exactly N cycles, then reports the final Gray value and whether the counter wrapped. It sits between the requesting FSMs and the counter's `Reset`/`En` inputs and owns the counter exclusively.

## Interface
- `LEN_W`, default 4: width of the step-count fields; the legal run length is 0 to 2^LEN_W-1.

- `Clk`, in, 1: clock, rising edge.
- `Reset`, in, 1: asynchronous, active-low reset.
- `Req`, in, 2: run request; bit 0 is requester A, bit 1 is requester B. It is level-sensitive.
- `LenA`, in, LEN_W: step count for A. Must be stable while `Req[0]` is high.
- `LenB`, in, LEN_W: step count for B. Must be stable while `Req[1]` is high.
- `Gnt`, out, 2: one-hot grant, high only during CLEAR.
- `Done`, out, 2: one-hot, one-cycle completion pulse to the granted requester.
- `Busy`, out, 1: high in every state except IDLE.
- `Result`, out, 3: counter value, valid only while `Done` is nonzero; 0 otherwise.
- `Wrap`, out, 1: counter overflow flag, valid only while `Done` is nonzero; 0 otherwise.
- `Cnt_clr`, out, 1: drives the counter's synchronous `Reset`.
- `Cnt_en`, out, 1: drives the counter's `En`.
- `Cnt_val`, in, 3: counter `Output`.
- `Cnt_ovf`, in, 1: counter `Overflow`, sticky until cleared.

## Operation
- The FSM has four states: IDLE, CLEAR, RUN and DONE. All outputs are Moore-decoded from the state registers. `Result` and `Wrap` are gated passthroughs during DONE.
- IDLE:
  - If `Req` is 0, stay in IDLE.
  - Otherwise pick a winner (see Configuration), latch that requester's Len into `rem` and the owner ID into `own`, and go to CLEAR.
- CLEAR: `Cnt_clr`=1 and `Gnt[own]`=1.
  - If `rem`=0, go to DONE.
  - Otherwise go to RUN.
- RUN: `Cnt_en`=1 and `rem` decrements on every cycle.
  - When `rem`=1, go to DONE.
  - RUN therefore lasts exactly Len cycles.
- DONE: `Done[own]`=1, `Result`=`Cnt_val` and `Wrap`=`Cnt_ovf`. Then go to IDLE.
- Required result: `Result` = Gray(Len mod 8), following the sequence 000, 001, 011, 010, 110, 111, 101, 100. `Wrap`=1 if and only if Len ≥ 8.
- Changes to `Req` or Len after the grant are ignored; the job always runs to completion. There is no abort.
- A requester that still holds `Req` in the IDLE cycle after its own DONE is treated as a new request.
- Reset (`Reset`=0), at any time including mid-run:
  - State returns to IDLE; `rem`, `own` and the priority pointer return to 0.
  - All outputs go to 0 immediately, including `Cnt_en` and `Cnt_clr`.
  - The counter is not cleared by reset; the next job's CLEAR cycle clears it.

## Timing
- Edge t samples `Req` in IDLE. CLEAR occupies cycle t+1, RUN occupies cycles t+2 to t+1+Len, and `Done` is high in cycle t+2+Len.
- Latency from the accepting edge to `Done` is Len+2 cycles. A job with Len=0 asserts `Done` 2 cycles after acceptance.
- There is one mandatory IDLE cycle between jobs. Back-to-back job throughput is therefore Len+3 cycles per job.
- The counter updates on the same edge that ends each RUN cycle. `Cnt_val` is therefore final during DONE, with no extra wait.
- `Gnt` and `Done` are each exactly one cycle wide. They are never high in the same cycle.

## Configuration
- `GRAY_CTRL_RR_EN` defined: round-robin arbitration.
  - A 1-bit priority pointer names the preferred requester. Its reset value is 0 (A preferred).
  - On each grant the pointer moves to the non-granted requester.
  - With both requests held continuously, grants alternate A, B, A, B.
- `GRAY_CTRL_RR_EN` undefined: fixed priority, with A always beating B. No pointer register exists. B can be starved.

## Test plan
- Reset, then `Req`=01 with LenA=3 → `Gnt`=01 for 1 cycle, `Cnt_en` high for 3 cycles, `Done`=01 with `Result`=010 and `Wrap`=0, 5 cycles after acceptance.
- `Req`=10 with LenB=9 → `Result`=001 and `Wrap`=1. Then LenB=0 → `Cnt_en` never rises, `Result`=000, `Wrap`=0, `Done` 2 cycles after acceptance.
- `Req`=11 held, LenA=1, LenB=2:
  - With RR: grants A, B, A, B and `Done` results 001, 011, 001, 011.
  - Without RR: grants A every time and B is never granted.
- `Req` dropped during RUN → the job still completes and `Done` is still asserted. There is no re-grant while `Req`=0.
- `Reset` asserted in the 2nd RUN cycle of a Len=5 job → all outputs read 0 in that same cycle. After release, a new Len=2 job returns `Result`=011 and `Wrap`=0.
- `Req`=01 with LenA=8 → `Result`=000 and `Wrap`=1. A following LenA=2 job → `Wrap`=0, because CLEAR cleared the sticky overflow.
